instr_fetch_unit: RTL and testbench



---
 rtl/kgp_fetch_pkg.sv | 22 ++
 rtl/fetch_timeout_ctr.sv | 42 ++++
 rtl/instr_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_fetch_pkg.sv
// Shared types and constants for the KGP instruction fetch stage.
package kgp_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      DRAIN = 3'd3,
      HOLD  = 3'd4,
      ERR   = 3'd5
   } fetch_state_e;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   // Instructions are word aligned; any set low bit is a fault.
   function automatic logic pc_aligned(input logic [1:0] pc_lsbs);
      return pc_lsbs == 2'b00;
   endfunction

endpackage : kgp_fetch_pkg

// File: rtl/fetch_timeout_ctr.sv
// Response timer shared by the WAIT and DRAIN states of the fetch FSM.
// expired_o is high during the TIMEOUT-th cycle after a clear.
module fetch_timeout_ctr #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int               CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, then count up, saturating at the last value.
   always_comb begin
      // NOTE: default first so every path assigns cnt_d; otherwise a latch is inferred.
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LAST);

endmodule : fetch_timeout_ctr

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: request/grant/response handshake with instruction
// memory, holds the fetched word until consumed, drains stale responses after
// a flush and latches misaligned-PC and timeout faults.
module instr_fetch_unit
   import kgp_fetch_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   input  logic              pc_valid,
   input  logic              flush,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   output logic              fetch_err,
   output logic [1:0]        err_code,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [1:0]        code_q, code_d;
   logic              req_q, req_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              tmr_clr, tmr_en, tmr_expired;

   // Timer restarts on every state change and only runs while awaiting a response.
   assign tmr_clr = (state_d != state_q);
   assign tmr_en  = (state_q == WAIT) || (state_q == DRAIN);

   fetch_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );

   // State and output registers; reset clears everything so all outputs read 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         instr_q <= '0;
         code_q  <= ERR_NONE;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         code_q  <= code_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic; flush takes priority over pc_valid everywhere.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (!flush && pc_valid) begin
               state_d = pc_aligned(pc[1:0]) ? REQ : ERR;
            end
         end
         REQ: begin
            if (flush) begin
               state_d = imem_gnt ? DRAIN : IDLE;
            end else if (imem_gnt) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (flush) begin
               state_d = imem_rvalid ? IDLE : DRAIN;
            end else if (imem_rvalid) begin
               state_d = HOLD;
            end else if (tmr_expired) begin
               state_d = ERR;
            end
         end
         DRAIN: begin
            if (imem_rvalid || tmr_expired) begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (flush) begin
               state_d = IDLE;
            end else if (instr_ready) begin
               if (pc_valid) begin
                  state_d = pc_aligned(pc[1:0]) ? REQ : ERR;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         ERR: begin
            if (flush) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output next values, derived from the transition about to be taken.
   always_comb begin
      addr_d  = addr_q;
      instr_d = instr_q;
      code_d  = code_q;
      req_d   = (state_d == REQ);
      valid_d = (state_d == HOLD);
      err_d   = (state_d == ERR);

      if ((state_d == REQ) && (state_q != REQ)) begin
         addr_d = pc;
      end
      if ((state_q == WAIT) && (state_d == HOLD)) begin
         instr_d = imem_rdata;
      end
      if (state_d != ERR) begin
         code_d = ERR_NONE;
      end else if (state_q != ERR) begin
         code_d = (state_q == WAIT) ? ERR_TIMEOUT : ERR_MISALIGN;
      end
   end

   assign instr       = instr_q;
   assign instr_pc    = addr_q;
   assign imem_addr   = addr_q;
   assign instr_valid = valid_q;
   assign fetch_err   = err_q;
   assign err_code    = code_q;
   assign imem_req    = req_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vectors, a flag-based behavioural
// model compared every cycle, and literal spot checks at key points.
module tb_instr_fetch_unit;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] pc;
   logic          pc_valid;
   logic          flush;
   logic          instr_ready;
   logic [DW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          instr_valid;
   logic          fetch_err;
   logic [1:0]    err_code;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [DW-1:0] imem_rdata;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   instr_fetch_unit #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .pc_valid    (pc_valid),
      .flush       (flush),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .fetch_err   (fetch_err),
      .err_code    (err_code),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what is pending with memory, what is presented, what fault is latched.
   typedef struct {
      bit          req;      // request posted, not yet granted
      bit          waiting;  // granted, response owed to us
      bit          drain;    // granted, response owed but unwanted
      bit          hold;     // word presented to the core
      bit          err;
      logic [1:0]  code;
      logic [31:0] pc;
      logic [31:0] instr;
      int          waited;   // cycles spent awaiting the response
   } model_t;

   model_t m;

   function automatic model_t accept_pc(input model_t s, input logic [31:0] a);
      if (a[1:0] != 2'b00) begin
         s.err  = 1'b1;
         s.code = 2'b01;
      end else begin
         s.req = 1'b1;
         s.pc  = a;
      end
      return s;
   endfunction

   always @(posedge clk) begin : model_step
      model_t n;
      n = m;
      if (rst) begin
         n = '{default: 0};
      end else if (m.err) begin
         if (flush) begin
            n.err  = 1'b0;
            n.code = 2'b00;
         end
      end else if (m.hold) begin
         if (flush) begin
            n.hold = 1'b0;
         end else if (instr_ready) begin
            n.hold = 1'b0;
            if (pc_valid) n = accept_pc(n, pc);
         end
      end else if (m.req) begin
         if (imem_gnt) begin
            n.req     = 1'b0;
            n.waited  = 0;
            n.drain   = flush;
            n.waiting = !flush;
         end else if (flush) begin
            n.req = 1'b0;
         end
      end else if (m.waiting) begin
         n.waited = m.waited + 1;
         if (imem_rvalid) begin
            n.waiting = 1'b0;
            if (!flush) begin
               n.hold  = 1'b1;
               n.instr = imem_rdata;
            end
         end else if (flush) begin
            n.waiting = 1'b0;
            n.drain   = 1'b1;
            n.waited  = 0;
         end else if (n.waited == TIMEOUT) begin
            n.waiting = 1'b0;
            n.err     = 1'b1;
            n.code    = 2'b10;
         end
      end else if (m.drain) begin
         n.waited = m.waited + 1;
         if (imem_rvalid || (n.waited == TIMEOUT)) n.drain = 1'b0;
      end else begin
         if (pc_valid && !flush) n = accept_pc(n, pc);
      end
      m <= n;
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_imem_req",    imem_req,    m.req);
         check("m_instr_valid", instr_valid, m.hold);
         check("m_fetch_err",   fetch_err,   m.err);
         check("m_err_code",    err_code,    m.code);
         if (m.req) check("m_imem_addr", imem_addr, m.pc);
         if (m.hold) begin
            check("m_instr",    instr,    m.instr);
            check("m_instr_pc", instr_pc, m.pc);
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; pc = '0; pc_valid = 1'b0; flush = 1'b0; instr_ready = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      cyc(); cyc();
      chk_en = 1'b1;
      check("rst_instr_valid", instr_valid, 0);
      check("rst_imem_req",    imem_req,    0);
      check("rst_fetch_err",   fetch_err,   0);
      rst = 1'b0;

      // Nominal fetch of 0x10.
      pc = 32'h10; pc_valid = 1'b1;
      cyc();
      check("nom_req",  imem_req,  1);
      check("nom_addr", imem_addr, 32'h10);
      imem_gnt = 1'b1;
      cyc();
      check("nom_req_drop", imem_req, 0);
      imem_gnt = 1'b0; pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2001_0005;
      cyc();
      imem_rvalid = 1'b0; imem_rdata = '0;
      check("nom_valid", instr_valid, 1);
      check("nom_instr", instr,       32'h2001_0005);
      check("nom_pc",    instr_pc,    32'h10);

      // Back-pressure: held stable, no new request.
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("bp_valid", instr_valid, 1);
         check("bp_instr", instr,       32'h2001_0005);
         check("bp_req",   imem_req,    0);
      end

      // Streaming 0x14 then 0x18 through HOLD->REQ.
      instr_ready = 1'b1; pc_valid = 1'b1; pc = 32'h14;
      cyc();
      check("s1_valid_fall", instr_valid, 0);
      check("s1_addr",       imem_addr,   32'h14);
      instr_ready = 1'b0; pc_valid = 1'b0; imem_gnt = 1'b1;
      cyc();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_1111;
      cyc();
      imem_rvalid = 1'b0;
      check("s1_instr", instr,    32'h0000_1111);
      check("s1_pc",    instr_pc, 32'h14);
      instr_ready = 1'b1; pc_valid = 1'b1; pc = 32'h18;
      cyc();
      instr_ready = 1'b0; pc_valid = 1'b0; imem_gnt = 1'b1;
      cyc();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_2222;
      cyc();
      imem_rvalid = 1'b0;
      check("s2_instr", instr,    32'h0000_2222);
      check("s2_pc",    instr_pc, 32'h18);
      instr_ready = 1'b1;
      cyc();
      instr_ready = 1'b0;
      check("s2_release", instr_valid, 0);

      // Flush in REQ without grant withdraws the request.
      pc_valid = 1'b1; pc = 32'h20;
      cyc();
      pc_valid = 1'b0; flush = 1'b1;
      cyc();
      flush = 1'b0;
      check("fr_req", imem_req, 0);

      // Flush one cycle after grant: the stale response is never presented.
      pc_valid = 1'b1; pc = 32'h30;
      cyc();
      pc_valid = 1'b0; imem_gnt = 1'b1;
      cyc();
      imem_gnt = 1'b0; flush = 1'b1;
      cyc();
      flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      cyc();
      imem_rvalid = 1'b0;
      check("fw_valid", instr_valid, 0);
      cyc();
      check("fw_valid2", instr_valid, 0);
      pc_valid = 1'b1; pc = 32'h40;
      cyc();
      pc_valid = 1'b0; imem_gnt = 1'b1;
      cyc();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
      cyc();
      imem_rvalid = 1'b0;
      check("fw_instr", instr,    32'h1234_5678);
      check("fw_pc",    instr_pc, 32'h40);
      instr_ready = 1'b1;
      cyc();
      instr_ready = 1'b0;

      // Misaligned PC latches code 01 until flush.
      pc_valid = 1'b1; pc = 32'h6;
      cyc();
      check("mis_err",  fetch_err, 1);
      check("mis_code", err_code,  2'b01);
      check("mis_req",  imem_req,  0);
      pc = 32'h20;
      cyc(); cyc();
      pc_valid = 1'b0;
      check("mis_stuck", fetch_err, 1);
      check("mis_noreq", imem_req,  0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      check("mis_clr_err",  fetch_err, 0);
      check("mis_clr_code", err_code,  2'b00);

      // Timeout: exactly TIMEOUT cycles in WAIT, then code 10.
      pc_valid = 1'b1; pc = 32'h50;
      cyc();
      pc_valid = 1'b0; imem_gnt = 1'b1;
      cyc();
      imem_gnt = 1'b0;
      repeat (TIMEOUT - 1) cyc();
      check("to_early", fetch_err, 0);
      cyc();
      check("to_err",  fetch_err, 1);
      check("to_code", err_code,  2'b10);
      imem_rvalid = 1'b1; imem_rdata = 32'h0000_BAD0;
      cyc();
      imem_rvalid = 1'b0;
      check("to_sticky", fetch_err,   1);
      check("to_novalid", instr_valid, 0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;

      // Reset while requesting without grant.
      pc_valid = 1'b1; pc = 32'h60;
      cyc();
      pc_valid = 1'b0;
      check("rr_req", imem_req, 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("rr_imem_req",    imem_req,    0);
      check("rr_imem_addr",   imem_addr,   0);
      check("rr_instr_valid", instr_valid, 0);
      check("rr_instr",       instr,       0);
      check("rr_instr_pc",    instr_pc,    0);
      check("rr_fetch_err",   fetch_err,   0);
      check("rr_err_code",    err_code,    0);
      cyc(); cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_instr_fetch_unit
